// File: rtl/mem_pkg.sv
// Shared memory-side definitions for the instruction cache: host op encodings,
// line geometry and the refill FSM state type.
package mem_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam int unsigned LINE_BITS      = 512;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned OFFSET_BITS    = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, one write port, synchronous clear of all valid bits.
module icache_array
  import mem_pkg::*;
#(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned TAG_W     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Valid bits: cleared by reset or invalidate; clear takes priority over a write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache in front of fetch. Hits return in the
// same cycle; misses fetch a 512-bit line from mem_ctrl, fill, then replay.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch
  import mem_pkg::*;
#(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 en,
  input  logic                 inv,
  output logic                 done,
  output logic [31:0]          data_out,
  output logic                 cache_hit,
  input  logic [LINE_BITS-1:0] DataIn_host,
  input  logic                 tx_done_host,
  input  logic                 rd_valid_host,
  output logic [LINE_BITS-1:0] DataOut_host,
  output logic [ADDR_W-1:0]    AddrOut_host,
`ifdef ICACHE_STATS_EN
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
`endif
  output logic [1:0]           op_host
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - OFFSET_BITS - IDX_W;

  icache_state_t        state_q, state_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic                 got_data_q, got_data_d;
  logic                 squash_q, squash_d;
  logic [LINE_BITS-1:0] line_buf_q;

  logic                 arr_valid;
  logic [TAG_W-1:0]     arr_tag;
  logic [LINE_BITS-1:0] arr_line;
  logic                 fill_we;
  logic                 hit;
  logic [3:0]           word;
  logic                 unused_addr_lo;

  assign word           = addr[OFFSET_BITS-1:2];
  assign unused_addr_lo = ^addr[1:0];

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clr      (inv),
    .rd_idx   (addr[OFFSET_BITS +: IDX_W]),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_line  (arr_line),
    .we       (fill_we),
    .wr_idx   (req_addr_q[OFFSET_BITS +: IDX_W]),
    .wr_tag   (req_addr_q[ADDR_W-1 -: TAG_W]),
    .wr_line  (line_buf_q)
  );

  assign hit = arr_valid && (arr_tag == addr[ADDR_W-1 -: TAG_W]);

  // FSM next-state and host/fetch outputs.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    got_data_d = got_data_q;
    squash_d   = squash_q;
    fill_we    = 1'b0;
    done       = 1'b0;
    op_host    = OP_NONE;
    unique case (state_q)
      IDLE: begin
        done = en && hit;
        if (en && !hit) begin
          state_d    = REQ;
          req_addr_d = {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          got_data_d = 1'b0;
          squash_d   = 1'b0;
        end
      end
      REQ: begin
        op_host = OP_READ;
        if (rd_valid_host) got_data_d = 1'b1;
        if (inv)           squash_d   = 1'b1;
        // A tx_done without any data keeps the read outstanding.
        if (tx_done_host && (got_data_q || rd_valid_host)) state_d = FILL;
      end
      FILL: begin
        fill_we = !squash_q && !inv;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and request bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      got_data_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      got_data_q <= got_data_d;
      squash_q   <= squash_d;
    end
  end

  // Line buffer captures returned data while the read is outstanding.
  always_ff @(posedge clk) begin
    if (state_q == REQ && rd_valid_host) begin
      line_buf_q <= DataIn_host;
    end
  end

  assign data_out     = done ? arr_line[{word, 5'b0} +: 32] : 32'h0;
  assign cache_hit    = done;
  assign DataOut_host = '0;
  assign AddrOut_host = req_addr_q;

`ifdef ICACHE_STATS_EN
  // Free-running hit/miss counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (done) hit_count <= hit_count + 32'd1;
      if (state_q == IDLE && state_d == REQ) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: the bench plays mem_ctrl and keeps a
// behavioural model of cache contents and the miss/refill protocol.
module tb_icache_fetch;
  import mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst, en, inv;
  logic [31:0]  addr;
  logic         done, cache_hit;
  logic [31:0]  data_out;
  logic [511:0] DataIn_host, DataOut_host;
  logic         tx_done_host, rd_valid_host;
  logic [31:0]  AddrOut_host;
  logic [1:0]   op_host;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  icache_fetch #(
    .NUM_LINES (64),
    .ADDR_W    (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .en            (en),
    .inv           (inv),
    .done          (done),
    .data_out      (data_out),
    .cache_hit     (cache_hit),
    .DataIn_host   (DataIn_host),
    .tx_done_host  (tx_done_host),
    .rd_valid_host (rd_valid_host),
    .DataOut_host  (DataOut_host),
    .AddrOut_host  (AddrOut_host),
`ifdef ICACHE_STATS_EN
    .hit_count     (hit_count),
    .miss_count    (miss_count),
`endif
    .op_host       (op_host)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory: every word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h11) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = mem_word(base + 32'(w * 4));
    return l;
  endfunction

  // Model: which lines are resident, and the progress of the current miss
  // (0 = serving lookups, 1 = waiting on memory, 2 = writing the line).
  bit          m_valid [64];
  logic [19:0] m_tag   [64];
  int          m_phase;
  logic [31:0] m_req;
  bit          m_got, m_squash;
  logic [31:0] m_hits, m_misses;

  // mem_ctrl responder.
  bit mem_auto = 1'b1;
  int mem_ctr, mem_lat, mem_split, forced_lat;
  bit mem_bogus;

  bit    chk_en = 1'b0;
  string cur = "init";
  bit    last_hit, obs_done;
  logic [31:0] obs_data;

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_phase  = 0;
    m_req    = '0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  // One clock: drive memory response, check outputs mid-cycle, advance the model.
  task automatic tick();
    logic [5:0]  idx;
    logic [19:0] tg;
    bit          hit;
    if (mem_auto) begin
      rd_valid_host = 1'b0;
      tx_done_host  = 1'b0;
      if (m_phase == 1) begin
        rd_valid_host = (mem_ctr == mem_lat);
        tx_done_host  = (mem_ctr == mem_lat + mem_split) || (mem_bogus && mem_ctr == 0);
        DataIn_host   = mk_line(m_req);
      end
    end
    @(negedge clk);
    idx = addr[11:6];
    tg  = addr[31:12];
    hit = (m_phase == 0) && en && m_valid[idx] && (m_tag[idx] == tg);
    last_hit = hit;
    obs_done = done;
    obs_data = data_out;
    if (chk_en) begin
      check({cur, "/done"}, 64'(done), 64'(hit));
      check({cur, "/cache_hit"}, 64'(cache_hit), 64'(hit));
      check({cur, "/data_out"}, 64'(data_out), 64'(hit ? mem_word({addr[31:2], 2'b00}) : 32'h0));
      check({cur, "/op_host"}, 64'(op_host), 64'((m_phase == 1) ? OP_READ : OP_NONE));
      check({cur, "/AddrOut_host"}, 64'(AddrOut_host), 64'(m_req));
      check({cur, "/DataOut_host"}, 64'(DataOut_host == '0), 64'(1));
`ifdef ICACHE_STATS_EN
      check({cur, "/hit_count"}, 64'(hit_count), 64'(m_hits));
      check({cur, "/miss_count"}, 64'(miss_count), 64'(m_misses));
`endif
    end
    if (rst) begin
      model_reset();
    end else begin
      if (hit) m_hits++;
      case (m_phase)
        0: if (en && !hit) begin
          m_phase   = 1;
          m_req     = {addr[31:6], 6'b0};
          m_got     = 1'b0;
          m_squash  = 1'b0;
          m_misses++;
          mem_ctr   = 0;
          mem_lat   = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 6));
          mem_split = (forced_lat > 0) ? 0 : int'($urandom_range(0, 2));
          mem_bogus = (forced_lat > 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
        end
        1: begin
          if (inv) m_squash = 1'b1;
          if (tx_done_host && (m_got || rd_valid_host)) m_phase = 2;
          if (rd_valid_host) m_got = 1'b1;
          mem_ctr++;
        end
        default: begin
          if (!m_squash && !inv) begin
            m_valid[m_req[11:6]] = 1'b1;
            m_tag[m_req[11:6]]   = m_req[31:12];
          end
          m_phase = 0;
        end
      endcase
      if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Look up an address until it hits; reports whether the first cycle hit.
  task automatic run_hit(input string tag, input logic [31:0] a, output bit first_done);
    bit got_hit = 1'b0;
    cur  = tag;
    addr = a;
    en   = 1'b1;
    for (int i = 0; i < 40 && !got_hit; i++) begin
      tick();
      if (i == 0) first_done = obs_done;
      got_hit = last_hit;
    end
    if (!got_hit) check({tag, "/timeout"}, 64'(0), 64'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (m_phase != 0 && n < 40) begin
      tick();
      n++;
    end
    if (m_phase != 0) check({tag, "/drain_timeout"}, 64'(0), 64'(1));
  endtask

  bit fd;

  initial begin
    rst = 1'b1; en = 1'b0; inv = 1'b0; addr = '0;
    DataIn_host = '0; tx_done_host = 1'b0; rd_valid_host = 1'b0;
    forced_lat = 0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    cur = "reset";
    tick();

    // Cold miss with a 5-cycle memory.
    forced_lat = 5;
    run_hit("cold", 32'h0000_0044, fd);
    check("cold/first_miss", 64'(fd), 64'(0));
    check("cold/replay_word", 64'(obs_data), 64'(32'hDEADBEEF));

    // Hit on another word of the same line.
    cur = "hit"; addr = 32'h0000_0048; tick();
    check("hit/same_cycle", 64'(obs_done), 64'(1));

    // Conflicting tag at the same index evicts the first line.
    run_hit("conflict", 32'h0000_1044, fd);
    check("conflict/miss", 64'(fd), 64'(0));
    run_hit("conflict_back", 32'h0000_0044, fd);
    check("conflict_back/remiss", 64'(fd), 64'(0));

    // Invalidate while the refill is outstanding.
    cur = "inv"; addr = 32'h0000_0080; tick();
    tick();
    inv = 1'b1; tick(); inv = 1'b0;
    drain("inv");
    run_hit("inv_after", 32'h0000_0080, fd);
    check("inv_after/remiss", 64'(fd), 64'(0));

    // Reset while REQ, data arrives afterwards.
    cur = "rst_req"; addr = 32'h0000_00C0; tick();
    tick();
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    mem_auto = 1'b0;
    rd_valid_host = 1'b1; tx_done_host = 1'b1; DataIn_host = mk_line(32'h0000_00C0);
    tick();
    check("rst_req/op_after", 64'(op_host), 64'(OP_NONE));
    mem_auto = 1'b1;
    forced_lat = 0;
    run_hit("rst_after", 32'h0000_00C0, fd);
    check("rst_after/remiss", 64'(fd), 64'(0));

    // en low: no hit, no request.
    cur = "en_low"; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      addr = 32'h8000_0000 | ($urandom_range(0, 1023) << 6);
      tick();
      check("en_low/op", 64'(op_host), 64'(OP_NONE));
    end

    // Randomized traffic over a small address pool so hits and conflicts recur.
    cur = "rand";
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      inv = ($urandom_range(0, 39) == 0);
      en  = !rst && ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 19) == 0) addr = $urandom();
      else addr = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 6) |
                  ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      tick();
    end
    rst = 1'b0; inv = 1'b0;
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
